// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction valid/ready handshake plus ALU operand/result bus.
interface alu_issue_ctrl_if #(parameter int DATA_W = 32);
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [5:0]        alu_op;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cout;
    logic              alu_z;
    logic              alu_n;
    modport master (output instr, instr_valid, alu_res, alu_cout, alu_z, alu_n,
                    input instr_ready, alu_a, alu_b, alu_op);
    modport slave (input instr, instr_valid, alu_res, alu_cout, alu_z, alu_n,
                   output instr_ready, alu_a, alu_b, alu_op);
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle decode/issue/writeback control in front of a 32-bit ALU.
module alu_issue_ctrl #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 3,
    parameter bit IMM_SIGNED = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_ctrl_if.slave    bus,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data,
    output logic               flag_c,
    output logic               flag_z,
    output logic               flag_n,
    output logic               err_illegal,
    output logic               busy,
    output logic               done
);
    localparam int NREG = 1 << REG_AW;
    localparam logic [5:0] OP_LOADI = 6'b000001;
    localparam logic [5:0] OP_CLRC  = 6'b000010;
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
    state_t            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [5:0]        op_q, op_d;
    logic              cout_q, cout_d, z_q, z_d, n_q, n_d;
    logic              fc_q, fc_d, fz_q, fz_d, fn_q, fn_d;
    logic              err_q, err_d, done_q, done_d, busy_q, busy_d, ready_q, ready_d;
    logic [5:0]        op;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic [DATA_W-1:0] imm_ext;
    logic              is_addsub, is_alu, is_local;
    assign op        = instr_q[31:26];
    assign rd        = instr_q[25:23];
    assign rs1       = instr_q[22:20];
    assign rs2       = instr_q[19:17];
    assign imm_ext   = IMM_SIGNED ? {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]}
                                  : {{(DATA_W-16){1'b0}}, instr_q[15:0]};
    assign is_addsub = op inside {6'b010000, 6'b010001};
    assign is_alu    = is_addsub || op inside {6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                               6'b110000, 6'b110001, 6'b110010};
    assign is_local  = op inside {6'b000000, OP_LOADI, OP_CLRC};
    // r0 is never written, so reading it directly yields zero
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        rf_d    = rf_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        cout_d  = cout_q;
        z_d     = z_q;
        n_d     = n_q;
        fc_d    = fc_q;
        fz_d    = fz_q;
        fn_d    = fn_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.instr_valid) begin
                instr_d = bus.instr;
                state_d = DECODE;
            end
            DECODE: begin
                state_d = is_alu ? EXEC : WB;
                if (is_alu) begin
                    a_d  = rf_q[rs1];
                    b_d  = instr_q[16] ? imm_ext : rf_q[rs2];
                    op_d = op;
                end
            end
            EXEC: begin
                res_d   = bus.alu_res;
                cout_d  = bus.alu_cout;
                z_d     = bus.alu_z;
                n_d     = bus.alu_n;
                state_d = WB;
            end
            WB: begin
                state_d = IDLE;
                if (is_alu) begin
                    if (rd != '0) rf_d[rd] = res_q;
                    fz_d = z_q;
                    fn_d = n_q;
                    fc_d = is_addsub ? cout_q : fc_q;
                end else if (op == OP_LOADI) begin
                    if (rd != '0) rf_d[rd] = imm_ext;
                end else if (op == OP_CLRC) begin
                    fc_d = 1'b0;
                end else if (!is_local) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d == IDLE;
        busy_d  = state_d != IDLE;
        done_d  = state_d == WB;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= '0;
            rf_q    <= '{default: '0};
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            fc_q    <= 1'b0;
            fz_q    <= 1'b0;
            fn_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            rf_q    <= rf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            z_q     <= z_d;
            n_q     <= n_d;
            fc_q    <= fc_d;
            fz_q    <= fz_d;
            fn_q    <= fn_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end
    assign bus.instr_ready = ready_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_op      = op_q;
    assign dbg_data        = rf_q[dbg_addr];
    assign flag_c          = fc_q;
    assign flag_z          = fz_q;
    assign flag_n          = fn_q;
    assign err_illegal     = err_q;
    assign busy            = busy_q;
    assign done            = done_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed test of alu_issue_ctrl against a behavioural 32-bit ALU.
module tb_alu_issue_ctrl;
    localparam logic [5:0] ADD = 6'b010000, SUB = 6'b010001, EQ = 6'b100000, NE = 6'b100001;
    localparam logic [5:0] LE = 6'b100010, GT = 6'b100011, LLS = 6'b110000, LRS = 6'b110001;
    localparam logic [5:0] ARS = 6'b110010, LOADI = 6'b000001, CLRC = 6'b000010, BAD = 6'b111111;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  dbg_addr = 3'd0;
    logic [31:0] dbg_data;
    logic        flag_c, flag_z, flag_n, err_illegal, busy, done;
    logic [32:0] wide;
    int          checks = 0;
    int          errors = 0;
    int          lat;
    alu_issue_ctrl_if #(.DATA_W(32)) bus ();
    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .err_illegal(err_illegal),
        .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    // behavioural ALU: compares unsigned, carry is meaningful only for ADD/SUB
    always_comb begin
        wide = '0;
        case (bus.alu_op)
            ADD: wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            SUB: wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            EQ:  wide[0] = bus.alu_a == bus.alu_b;
            NE:  wide[0] = bus.alu_a != bus.alu_b;
            LE:  wide[0] = bus.alu_a <= bus.alu_b;
            GT:  wide[0] = bus.alu_a > bus.alu_b;
            LLS: wide[31:0] = bus.alu_a << bus.alu_b[4:0];
            LRS: wide[31:0] = bus.alu_a >> bus.alu_b[4:0];
            ARS: wide[31:0] = $signed(bus.alu_a) >>> bus.alu_b[4:0];
            default: wide = '0;
        endcase
        bus.alu_res  = wide[31:0];
        bus.alu_cout = wide[32];
        bus.alu_z    = wide[31:0] == 32'd0;
        bus.alu_n    = wide[31];
    end
    function automatic logic [31:0] enc(logic [5:0] op, logic [2:0] rd, logic [2:0] rs1,
                                        logic [2:0] rs2, logic isel, logic [15:0] imm);
        return {op, rd, rs1, rs2, isel, imm};
    endfunction
    // lat = falling edges after the accepting edge until done is seen, -1 on timeout
    task automatic issue(input logic [31:0] w, output int l);
        int n = 0;
        @(negedge clk);
        bus.instr = w;
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        l = -1;
        if (bus.instr_ready) begin
            @(posedge clk);
            @(negedge clk);
            bus.instr_valid = 1'b0;
            l = 1;
            while (!done && l < 10) begin
                @(negedge clk);
                l++;
            end
            if (!done) l = -1;
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
    endtask
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, err_illegal} !== 3'b000) begin errors++; $display("FAIL rst_status: got %b expected 000", {busy, done, err_illegal}); end
        checks++; if ({flag_c, flag_z, flag_n} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {flag_c, flag_z, flag_n}); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 70'd0) begin errors++; $display("FAIL rst_alu_bus: got %h expected 0", {bus.alu_a, bus.alu_b, bus.alu_op}); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", bus.instr_ready); end
    endtask
    task automatic test_add();
        issue(enc(LOADI, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF), lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL loadi_lat: got %0d expected 2", lat); end
        issue(enc(LLS, 3'd1, 3'd1, 3'd0, 1'b1, 16'd16), lat);
        dbg_addr = 3'd1; #1;
        checks++; if (dbg_data !== 32'hFFFF0000) begin errors++; $display("FAIL lls_r1: got %h expected ffff0000", dbg_data); end
        issue(enc(LOADI, 3'd3, 3'd0, 3'd0, 1'b1, 16'hFFFF), lat);
        issue(enc(ADD, 3'd4, 3'd1, 3'd3, 1'b0, 16'd0), lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL add_lat: got %0d expected 3", lat); end
        dbg_addr = 3'd4; #1;
        checks++; if (dbg_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL add_r4: got %h expected ffffffff", dbg_data); end
        checks++; if ({flag_c, flag_z, flag_n} !== 3'b001) begin errors++; $display("FAIL add_r4_flags: got %b expected 001", {flag_c, flag_z, flag_n}); end
        issue(enc(ADD, 3'd5, 3'd4, 3'd0, 1'b1, 16'd1), lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL add2_lat: got %0d expected 3", lat); end
        dbg_addr = 3'd5; #1;
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL add_r5: got %h expected 0", dbg_data); end
        checks++; if ({flag_c, flag_z, flag_n} !== 3'b110) begin errors++; $display("FAIL add_r5_flags: got %b expected 110", {flag_c, flag_z, flag_n}); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {32'hFFFFFFFF, 32'd1, ADD}) begin errors++; $display("FAIL alu_hold: got %h expected %h", {bus.alu_a, bus.alu_b, bus.alu_op}, {32'hFFFFFFFF, 32'd1, ADD}); end
    endtask
    task automatic test_sub_clrc();
        issue(enc(LOADI, 3'd1, 3'd0, 3'd0, 1'b1, 16'd3), lat);
        issue(enc(SUB, 3'd2, 3'd1, 3'd0, 1'b1, 16'd5), lat);
        dbg_addr = 3'd2; #1;
        checks++; if (dbg_data !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_r2: got %h expected fffffffe", dbg_data); end
        checks++; if ({flag_c, flag_z, flag_n} !== 3'b101) begin errors++; $display("FAIL sub_flags: got %b expected 101", {flag_c, flag_z, flag_n}); end
        issue(enc(CLRC, 3'd0, 3'd0, 3'd0, 1'b0, 16'd0), lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL clrc_lat: got %0d expected 2", lat); end
        checks++; if ({flag_c, flag_z, flag_n} !== 3'b001) begin errors++; $display("FAIL clrc_flags: got %b expected 001", {flag_c, flag_z, flag_n}); end
    endtask
    task automatic test_compare_shift();
        issue(enc(ADD, 3'd6, 3'd4, 3'd0, 1'b1, 16'd1), lat);
        issue(enc(GT, 3'd3, 3'd1, 3'd0, 1'b1, 16'd2), lat);
        dbg_addr = 3'd3; #1;
        checks++; if (dbg_data !== 32'd1) begin errors++; $display("FAIL gt_r3: got %h expected 1", dbg_data); end
        checks++; if ({flag_c, flag_z, flag_n} !== 3'b100) begin errors++; $display("FAIL gt_flags: got %b expected 100", {flag_c, flag_z, flag_n}); end
        issue(enc(EQ, 3'd3, 3'd1, 3'd0, 1'b1, 16'd2), lat);
        dbg_addr = 3'd3; #1;
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL eq_r3: got %h expected 0", dbg_data); end
        checks++; if ({flag_c, flag_z, flag_n} !== 3'b110) begin errors++; $display("FAIL eq_flags: got %b expected 110", {flag_c, flag_z, flag_n}); end
        issue(enc(LOADI, 3'd2, 3'd0, 3'd0, 1'b1, 16'h8000), lat);
        issue(enc(LLS, 3'd2, 3'd2, 3'd0, 1'b1, 16'd16), lat);
        issue(enc(ARS, 3'd5, 3'd2, 3'd0, 1'b1, 16'd4), lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ars_lat: got %0d expected 3", lat); end
        dbg_addr = 3'd5; #1;
        checks++; if (dbg_data !== 32'hF8000000) begin errors++; $display("FAIL ars_r5: got %h expected f8000000", dbg_data); end
        checks++; if ({flag_c, flag_z, flag_n} !== 3'b101) begin errors++; $display("FAIL ars_flags: got %b expected 101", {flag_c, flag_z, flag_n}); end
    endtask
    task automatic test_back_to_back();
        logic [31:0] prog [4];
        int at [4];
        int k = 0, cyc = 0, dones = 0;
        logic acc;
        prog[0] = enc(ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd10);
        prog[1] = enc(ADD, 3'd2, 3'd1, 3'd0, 1'b1, 16'd20);
        prog[2] = enc(SUB, 3'd3, 3'd2, 3'd0, 1'b1, 16'd5);
        prog[3] = enc(ADD, 3'd4, 3'd3, 3'd1, 1'b0, 16'd0);
        for (int i = 0; i < 4; i++) at[i] = 0;
        while (cyc < 40 && !(k == 4 && dones == 4)) begin
            @(negedge clk);
            bus.instr_valid = k < 4;
            if (k < 4) bus.instr = prog[k];
            if (done) dones++;
            acc = bus.instr_ready && bus.instr_valid;
            @(posedge clk);
            cyc++;
            if (acc) begin
                at[k] = cyc;
                k++;
            end
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        checks++; if (k !== 4 || dones !== 4) begin errors++; $display("FAIL b2b_count: got %0d accepted %0d done expected 4 4", k, dones); end
        checks++; if (at[1] - at[0] !== 4 || at[2] - at[1] !== 4 || at[3] - at[2] !== 4) begin errors++; $display("FAIL b2b_spacing: got %0d %0d %0d %0d expected step 4", at[0], at[1], at[2], at[3]); end
        dbg_addr = 3'd1; #1;
        checks++; if (dbg_data !== 32'd10) begin errors++; $display("FAIL b2b_r1: got %h expected a", dbg_data); end
        dbg_addr = 3'd2; #1;
        checks++; if (dbg_data !== 32'd30) begin errors++; $display("FAIL b2b_r2: got %h expected 1e", dbg_data); end
        dbg_addr = 3'd3; #1;
        checks++; if (dbg_data !== 32'd25) begin errors++; $display("FAIL b2b_r3: got %h expected 19", dbg_data); end
        dbg_addr = 3'd4; #1;
        checks++; if (dbg_data !== 32'd35) begin errors++; $display("FAIL b2b_r4: got %h expected 23", dbg_data); end
    endtask
    task automatic test_illegal();
        issue(enc(SUB, 3'd7, 3'd0, 3'd0, 1'b1, 16'd1), lat);
        issue(enc(BAD, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0055), lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL illegal_lat: got %0d expected 2", lat); end
        checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b expected 1", err_illegal); end
        dbg_addr = 3'd1; #1;
        checks++; if (dbg_data !== 32'd10) begin errors++; $display("FAIL illegal_r1: got %h expected a", dbg_data); end
        checks++; if ({flag_c, flag_z, flag_n} !== 3'b101) begin errors++; $display("FAIL illegal_flags: got %b expected 101", {flag_c, flag_z, flag_n}); end
        issue(enc(LOADI, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234), lat);
        dbg_addr = 3'd0; #1;
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL r0_write: got %h expected 0", dbg_data); end
        checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err_illegal); end
    endtask
    task automatic test_reset_mid();
        @(negedge clk);
        bus.instr = enc(ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'd7);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL mid_exec_state: got busy %b done %b expected 1 0", busy, done); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        dbg_addr = 3'd2;
        repeat (3) @(negedge clk);
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL mid_r2: got %h expected 0", dbg_data); end
        checks++; if ({flag_c, flag_z, flag_n, err_illegal} !== 4'b0000) begin errors++; $display("FAIL mid_flags: got %b expected 0000", {flag_c, flag_z, flag_n, err_illegal}); end
        checks++; if (busy !== 1'b0 || bus.instr_ready !== 1'b1) begin errors++; $display("FAIL mid_idle: got busy %b ready %b expected 0 1", busy, bus.instr_ready); end
        issue(enc(LOADI, 3'd2, 3'd0, 3'd0, 1'b1, 16'd5), lat);
        dbg_addr = 3'd2; #1;
        checks++; if (dbg_data !== 32'd5) begin errors++; $display("FAIL post_reset_loadi: got %h expected 5", dbg_data); end
    endtask
    initial begin
        bus.instr = '0;
        bus.instr_valid = 1'b0;
        test_reset();
        test_add();
        test_sub_clrc();
        test_compare_shift();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle control unit that sits directly upstream of the 32-bit ALU.
- Accepts 32-bit instructions over a valid/ready handshake and holds an 8-entry register file.
- Decodes each instruction, drives the ALU operands and 6-bit opCode, samples the result and flags, then writes back to the register file.
- Keeps architectural C/Z/N flags and a sticky illegal-opcode error.

Parameters:
- DATA_W, 32, datapath width; fixed by ALU width.
- REG_AW, 3, register address width; instruction format is defined for 3.
- IMM_SIGNED, 0, immediate extension: 0 = zero-extend imm16, 1 = sign-extend.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction word
- instr_valid  in  1  instr is valid
- instr_ready  out  1  block can accept an instruction
- alu_a  out  DATA_W  ALU operand a
- alu_b  out  DATA_W  ALU operand b
- alu_op  out  6  ALU opCode
- alu_res  in  DATA_W  ALU ans1
- alu_cout  in  1  ALU ans2 (carry/borrow)
- alu_z  in  1  ALU zero flag
- alu_n  in  1  ALU negative flag
- dbg_addr  in  REG_AW  debug register read address
- dbg_data  out  DATA_W  combinational read of regfile[dbg_addr]
- flag_c, flag_z, flag_n  out  1 each  architectural flags
- err_illegal  out  1  sticky illegal-opcode flag
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse in WB

Behaviour:
- Clock and reset:
  - Single clock; reset is asynchronous and active-low.
  - On rst_n=0: state=IDLE, all regfile entries=0, alu_a=alu_b=0, alu_op=6'b000000, flags=0, err_illegal=0, done=0, busy=0, instr_ready=1 once reset releases.
- Instruction format:
  - [31:26] op, [25:23] rd, [22:20] rs1, [19:17] rs2, [16] imm_sel, [15:0] imm16.
  - Operand b = imm_sel ? ext(imm16) : R[rs2].
  - Operand a = R[rs1].
- r0 reads as 0. Writes to r0 are discarded, but flags still update.
- ALU ops (forwarded unchanged on alu_op):
  - 010000 ADD, 010001 SUB.
  - 100000 EQ, 100001 NE, 100010 LE, 100011 GT.
  - 110000 LLS, 110001 LRS, 110010 ARS.
- Local ops (ALU not used):
  - 000000 NOP.
  - 000001 LOADI: R[rd] = ext(imm16).
  - 000010 CLRC: flag_c = 0.
- Any other op is illegal: err_illegal is set (cleared only by reset); no regfile or flag change; done still pulses.
- FSM states IDLE, DECODE, EXEC, WB:
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to DECODE.
  - DECODE: read operands. For an ALU op, register alu_a/alu_b/alu_op and go to EXEC; otherwise go to WB.
  - EXEC: ALU inputs held stable for the full cycle. At the end of the cycle, capture alu_res/alu_cout/alu_z/alu_n.
  - WB: done=1. ALU op: R[rd]=captured result; flag_z/flag_n=captured values; flag_c=captured cout for ADD/SUB only, unchanged otherwise. Next state is IDLE.
- Latency from acceptance edge to done: ALU op = 3 cycles, local/illegal op = 2 cycles.
- Throughput: one instruction per 4 cycles (ALU op) or 3 cycles (local/illegal op). instr_ready is low outside IDLE; valid held high during busy is ignored, not queued.
- alu_a/alu_b/alu_op hold their last driven values outside EXEC; they are not cleared.
- Hazards: none. Each instruction fully retires before the next is accepted, so rd==rs1 and similar cases are safe.
- Reset asserted mid-operation: immediate return to IDLE; the in-flight instruction is dropped with no writeback and no flag update.

Test Plan:
1. Reset, then LOADI r1,0xFFFF; LLS r1,r1,imm 16; LOADI r3,0xFFFF; ADD r4,r1,r3 -> r4=0xFFFFFFFF, flag_n=1, flag_z=0. Then ADD r5,r4,imm 1 -> r5=0, flag_z=1, flag_c=1. Each ADD shows done exactly 3 cycles after acceptance.
2. LOADI r1,3; SUB r2,r1,imm 5 -> r2=0xFFFFFFFE, flag_c=1, flag_n=1. Then CLRC -> flag_c=0 with flag_z/flag_n unchanged.
3. GT r3,r1,imm 2 with r1=3 -> r3=1, flag_z=0; EQ r3,r1,imm 2 -> r3=0, flag_z=1; ARS on 0x80000000 by 4 -> matches ALU output, written to rd.
4. instr_valid held high continuously with 4 ALU ops queued at the source -> instr_ready pulses once every 4 cycles; all 4 retire in order; no instruction lost or duplicated.
5. op=6'b111111 -> err_illegal=1 and remains set; regfile and flags unchanged; done pulses 2 cycles after acceptance. LOADI r0,0x1234 -> dbg_data at addr 0 stays 0.
6. Assert rst_n low during EXEC of ADD r2,... -> r2 stays 0 after reset, flags=0, busy=0, instr_ready=1 on reset release.
